// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline: ALU opcodes, default widths and
// the packed control bundle that travels from decode into execute.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RA_W_DEFAULT = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: the youngest in-flight writer of a register wins,
// and x0 is never forwarded because it is hardwired to zero.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);

  always_comb begin
    fwd_data = rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
      fwd_data = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// global hold and branch flush. Drives the ALU operands directly.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            stall_o
);

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            alu_src_q, alu_src_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  // Index 0 is rs1, index 1 is rs2.
  logic [RA_W-1:0] rs_addr_q [2];
  logic [RA_W-1:0] rs_addr_d [2];
  logic [XLEN-1:0] rs_data_q [2];
  logic [XLEN-1:0] rs_data_d [2];
  logic [RA_W-1:0] id_rs_addr [2];
  logic [XLEN-1:0] id_rs_data [2];
  logic [XLEN-1:0] fwd_data [2];
  ctrl_t           id_ctrl;

  assign id_rs_addr[0] = id_rs1_addr;
  assign id_rs_addr[1] = id_rs2_addr;
  assign id_rs_data[0] = id_rs1_data;
  assign id_rs_data[1] = id_rs2_data;
  assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read,
                     mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                     branch: id_branch};

  // Consumer in decode needs a value the load in EX has not fetched yet.
  assign stall_o = id_valid && !flush_i && valid_q && ctrl_q.mem_read &&
                   (rd_q != '0) && ((rd_q == id_rs1_addr) || (rd_q == id_rs2_addr));

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    alu_src_d  = alu_src_q;
    alu_ctrl_d = alu_ctrl_q;
    rs_addr_d  = rs_addr_q;
    rs_data_d  = rs_data_q;
    if (!hold_i) begin
      if (flush_i || stall_o) begin
        valid_d    = 1'b0;
        ctrl_d     = CTRL_BUBBLE;
        rd_d       = '0;
        imm_d      = '0;
        alu_src_d  = 1'b0;
        alu_ctrl_d = OP_ADD;
        for (int i = 0; i < 2; i++) begin
          rs_addr_d[i] = '0;
          rs_data_d[i] = '0;
        end
      end else begin
        valid_d    = id_valid;
        ctrl_d     = id_ctrl;
        rd_d       = id_rd_addr;
        imm_d      = id_imm;
        alu_src_d  = id_alu_src;
        alu_ctrl_d = id_alu_ctrl;
        rs_addr_d  = id_rs_addr;
        rs_data_d  = id_rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_src_q  <= 1'b0;
      alu_ctrl_q <= OP_ADD;
      for (int i = 0; i < 2; i++) begin
        rs_addr_q[i] <= '0;
        rs_data_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      alu_src_q  <= alu_src_d;
      alu_ctrl_q <= alu_ctrl_d;
      rs_addr_q  <= rs_addr_d;
      rs_data_q  <= rs_data_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_mux (
      .rs_addr         (rs_addr_q[gi]),
      .rs_data         (rs_data_q[gi]),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .fwd_data        (fwd_data[gi])
    );
  end

  assign alu_a         = fwd_data[0];
  assign alu_b         = alu_src_q ? imm_q : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each stimulus cycle pushes the expected
// EX-side view, and a monitor compares it on the following falling edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        hold_i, flush_i;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic        stall_o;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .hold_i(hold_i), .flush_i(flush_i),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  ctl;  // {reg_write, mem_read, mem_write, mem_to_reg, branch}
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] a, b, sd;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  int checks_total  = 0;
  int checks_passed = 0;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_ALU   = 5'b10000;
  localparam logic [4:0] C_LOAD  = 5'b11010;
  localparam logic [4:0] C_STORE = 5'b00100;
  localparam logic [4:0] C_BR    = 5'b00001;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [4:0] ctl,
                            input logic [4:0] rd, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] sd, input logic st);
    exp_t e;
    e.name = nm; e.valid = v; e.ctl = ctl; e.rd = rd; e.op = op;
    e.a = a; e.b = b; e.sd = sd; e.stall = st;
    exp_q.push_back(e);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src, input logic [3:0] op,
                        input logic [4:0] rd, input logic [4:0] ctl);
    id_valid = v; id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2;
    id_rs2_data = d2; id_imm = imm; id_alu_src = src; id_alu_ctrl = op;
    id_rd_addr = rd;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = ctl;
  endtask

  task automatic set_idle();
    set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'b0010, 5'd0, C_NONE);
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mr);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = er;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mr;
  endtask

  // Monitor: compares the head expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    logic [4:0] ctl_act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ctl_act = {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch};
        checks_total++;
        if (ex_valid === e.valid && ctl_act === e.ctl && ex_rd === e.rd &&
            alu_ctrl === e.op && alu_a === e.a && alu_b === e.b &&
            ex_store_data === e.sd && stall_o === e.stall) begin
          checks_passed++;
          $display("ok   %-18s v=%b ctl=%b rd=%0d op=%b a=%h b=%h sd=%h stall=%b",
                   e.name, ex_valid, ctl_act, ex_rd, alu_ctrl, alu_a, alu_b,
                   ex_store_data, stall_o);
        end else begin
          $display("FAIL %s: got v=%b ctl=%b rd=%0d op=%b a=%h b=%h sd=%h stall=%b; want v=%b ctl=%b rd=%0d op=%b a=%h b=%h sd=%h stall=%b",
                   e.name, ex_valid, ctl_act, ex_rd, alu_ctrl, alu_a, alu_b,
                   ex_store_data, stall_o, e.valid, e.ctl, e.rd, e.op, e.a, e.b,
                   e.sd, e.stall);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    set_idle();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    next_cycle();
    expect_out("reset", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    rst_n = 1'b1;
    set_id(1, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 1, 4'b0010, 5'd6, C_ALU);
    expect_out("idle_before_load", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    set_idle();
    expect_out("plain_load", 1, C_ALU, 6, 4'b0010, 32'd5, 32'd7, 32'd9, 0);

    next_cycle();
    set_id(1, 5'd3, 32'h11, 5'd0, 32'h22, 32'h0, 0, 4'b0110, 5'd7, C_NONE);
    expect_out("idle_capture", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    expect_out("fwd_exmem_wins", 1, C_NONE, 7, 4'b0110, 32'hAA, 32'h22, 32'h22, 0);

    next_cycle();
    exmem_reg_write = 1'b0;
    expect_out("fwd_memwb", 1, C_NONE, 7, 4'b0110, 32'hBB, 32'h22, 32'h22, 0);

    next_cycle();
    set_id(1, 5'd0, 32'h33, 5'd0, 32'h44, 32'h0, 0, 4'b0001, 5'd1, C_NONE);
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    expect_out("fwd_none", 1, C_NONE, 7, 4'b0110, 32'h11, 32'h22, 32'h22, 0);

    next_cycle();
    set_id(1, 5'd8, 32'h1, 5'd5, 32'h55, 32'h100, 1, 4'b0010, 5'd9, C_STORE);
    expect_out("fwd_x0", 1, C_NONE, 1, 4'b0001, 32'h33, 32'h44, 32'h44, 0);

    next_cycle();
    set_id(1, 5'd1, 32'h10, 5'd0, 32'h0, 32'd4, 1, 4'b0010, 5'd4, C_LOAD);
    set_fwd(1'b1, 5'd6, 32'hAA, 1'b1, 5'd5, 32'hBB);
    expect_out("store_fwd_rs2", 1, C_STORE, 9, 4'b0010, 32'h1, 32'h100, 32'hBB, 0);

    next_cycle();
    set_id(1, 5'd2, 32'h20, 5'd4, 32'h30, 32'h0, 0, 4'b0010, 5'd10, C_ALU);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_out("load_use_stall", 1, C_LOAD, 4, 4'b0010, 32'h10, 32'd4, 32'h0, 1);

    next_cycle();
    expect_out("load_use_bubble", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    set_id(1, 5'd1, 32'h10, 5'd0, 32'h0, 32'd4, 1, 4'b0010, 5'd4, C_LOAD);
    expect_out("load_use_replay", 1, C_ALU, 10, 4'b0010, 32'h20, 32'h30, 32'h30, 0);

    next_cycle();
    set_id(1, 5'd4, 32'h20, 5'd0, 32'h0, 32'h0, 0, 4'b0010, 5'd10, C_ALU);
    flush_i = 1'b1;
    expect_out("flush_kills_stall", 1, C_LOAD, 4, 4'b0010, 32'h10, 32'd4, 32'h0, 0);

    next_cycle();
    flush_i = 1'b0;
    set_id(1, 5'd3, 32'h77, 5'd2, 32'h88, 32'h0, 0, 4'b0001, 5'd11, C_BR);
    expect_out("flush_bubble", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    hold_i = 1'b1; flush_i = 1'b1;
    set_id(1, 5'd9, 32'h99, 5'd9, 32'h99, 32'h5, 1, 4'b0110, 5'd12, C_ALU);
    expect_out("pre_hold", 1, C_BR, 11, 4'b0001, 32'h77, 32'h88, 32'h88, 0);

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 2) hold_i = 1'b0;
      expect_out($sformatf("hold_cycle_%0d", i + 1), 1, C_BR, 11, 4'b0001,
                 32'h77, 32'h88, 32'h88, 0);
    end

    next_cycle();
    flush_i = 1'b0;
    set_idle();
    expect_out("flush_after_hold", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    set_id(1, 5'd1, 32'd5, 5'd2, 32'd6, 32'd7, 1, 4'b0010, 5'd3, C_ALU);
    expect_out("idle_again", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    next_cycle();
    expect_out("pre_reset", 1, C_ALU, 3, 4'b0010, 32'd5, 32'd7, 32'd6, 0);

    next_cycle();
    #2;
    rst_n = 1'b0;
    expect_out("async_reset", 0, C_NONE, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
      checks_total += exp_q.size();
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU.
- Captures decoded instruction fields and control bits from decode, then drives ALU operands A and B and the 4-bit ALU control.
- Resolves data hazards with EX/MEM and MEM/WB forwarding, and inserts load-use bubbles.
- Honours pipeline-wide hold and branch flush.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W each  register indices
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_src  in  1  1 = B operand is immediate
- id_alu_ctrl  in  4  ALU opcode (AND 0000, OR 0001, ADD 0010, SUB 0110)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control bits
- exmem_rd  in  RA_W  destination in EX/MEM
- exmem_reg_write  in  1  EX/MEM writes the register file
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_rd  in  RA_W  destination in MEM/WB
- memwb_reg_write  in  1  MEM/WB writes the register file
- memwb_result  in  XLEN  MEM/WB writeback value
- hold_i  in  1  global freeze (memory stall)
- flush_i  in  1  kill the decode-slot instruction (taken branch)
- alu_a, alu_b  out  XLEN each  ALU operands
- alu_ctrl  out  4  ALU opcode
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_rd  out  RA_W  destination register
- ex_valid  out  1  EX slot valid
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control bits
- stall_o  out  1  load-use stall request to IF/ID

Behaviour:
- Reset (rst_n low, asynchronous): all EX registers clear.
  - ex_valid = 0, all control bits = 0, ex_rd = 0.
  - Registered rs1/rs2/imm = 0; alu_ctrl = 0010 (ADD).
  - Resulting outputs: alu_a = 0, alu_b = 0, ex_store_data = 0, stall_o = 0.
  - Release of reset is synchronised externally.
- Register update priority on each rising clk edge:
  1. hold_i = 1: all EX registers keep their value; flush_i and stall are ignored. Upstream keeps flush_i asserted until hold drops.
  2. flush_i = 1: load a bubble.
  3. stall_o = 1: load a bubble.
  4. Otherwise: load all id_* fields; ex_valid <= id_valid.
- Bubble: ex_valid = 0, all control bits = 0, ex_rd = 0, alu_ctrl = ADD, data registers = 0.
- Load-use stall (combinational):
  - stall_o = id_valid & !flush_i & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr)).
  - stall_o is not gated by hold_i.
- Forwarding (combinational, computed separately for rs1 and rs2 from the registered addresses):
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == rsN: use exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == rsN: use memwb_result.
  - Else: use the registered rsN data.
  - EX/MEM always wins over MEM/WB. Register x0 is never forwarded.
- Operand select:
  - alu_a = forwarded rs1.
  - alu_b = ex_alu_src ? imm : forwarded rs2.
  - ex_store_data = forwarded rs2, regardless of alu_src.
- Latency: one cycle from the ID inputs to the EX registers. Forwarding muxes add zero cycles.
- Forwarding muxes remain active while ex_valid = 0; downstream qualifies on ex_valid.

Decomposition:
- Package riscv_pkg:
  - ALU opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB.
  - XLEN and RA_W defaults.
  - Packed struct ctrl_t {reg_write, mem_read, mem_write, mem_to_reg, branch}, with a CTRL_BUBBLE constant.
- Sub-module fwd_mux:
  - Instantiated twice, once each for rs1 and rs2.
  - Inputs: rs address, register value, EX/MEM triple, MEM/WB triple. Output: selected value.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle while ex_valid = 1 -> ex_valid, alu_a, alu_b go to 0 and alu_ctrl to 0010 immediately, without waiting for a clock edge.
- Plain load: id_rs1_data = 5, id_imm = 7, id_alu_src = 1, id_alu_ctrl = ADD -> next cycle alu_a = 5, alu_b = 7, alu_ctrl = 0010, ex_valid = 1.
- Double hazard: rs1 = x3, exmem_rd = 3 with result 0xAA, memwb_rd = 3 with result 0xBB, both write enables set -> alu_a = 0xAA. With exmem_reg_write = 0 -> alu_a = 0xBB. With rs1 = x0 and both rd = 0 -> alu_a = registered value.
- Load-use: EX holds a load (mem_read = 1) to x4; ID uses rs2 = x4 -> stall_o = 1, next cycle ex_valid = 0 with all controls 0. Following cycle the same ID instruction is captured.
- Flush during stall: flush_i = 1 together with the load-use condition -> stall_o = 0 and a bubble is loaded.
- Hold: hold_i = 1 with flush_i = 1 for 3 cycles -> EX registers unchanged throughout. First edge after hold drops loads a bubble.
